// File: rtl/rx_seq_pkg.sv
`default_nettype none
// ============================================================================
// rx_seq_pkg : shared types for the serial receive bit sequencer
// Rev 1.0
// ============================================================================
package rx_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        LOAD  = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ============================================================================
// rx_bit_timer : bit-period and bit-count timing for the receive sequencer
// Rev 1.0
// ============================================================================
module rx_bit_timer #(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count_en,
    input  logic restart,
    input  logic bit_inc,
    output logic half_done,
    output logic period_pre,
    output logic period_done,
    output logic bits_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(NUM_DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] PERIOD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BITS_LAST   = BIT_W'(NUM_DATA_BITS - 1);

    logic [CNT_W-1:0] clk_cnt;
    logic [BIT_W-1:0] bit_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            if (restart) begin
                clk_cnt <= '0;
            end else if (count_en) begin
                clk_cnt <= clk_cnt + CNT_W'(1);
            end
            if (bit_inc) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

    // period_pre lets the FSM register the strobe so it lands on the last count
    assign half_done   = (clk_cnt == HALF_LAST);
    assign period_pre  = (clk_cnt == PERIOD_PRE);
    assign period_done = (clk_cnt == PERIOD_LAST);
    assign bits_done   = (bit_cnt == BITS_LAST);

endmodule
`default_nettype wire

// File: rtl/rx_bit_sequencer.sv
`default_nettype none
// ============================================================================
// rx_bit_sequencer : start detection, mid-bit sampling and status for a UART RX
// Rev 1.0
// ============================================================================
module rx_bit_sequencer
    import rx_seq_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic data_read,
    output logic shift_strobe,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic busy
);

    logic      sync_meta;
    logic      rx_s;
    logic      rx_prev;
    logic      start_edge;
    rx_state_t state;

    logic tmr_clear;
    logic tmr_count;
    logic tmr_restart;
    logic tmr_bit_inc;
    logic half_done;
    logic period_pre;
    logic period_done;
    logic bits_done;

    // Line idles high, so the history resets high to avoid a phantom start
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_meta <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            rx_s      <= sync_meta;
            rx_prev   <= rx_s;
        end
    end

    assign start_edge  = rx_prev & ~rx_s;
    assign tmr_clear   = (state == IDLE);
    assign tmr_count   = (state == START) || (state == DATA) || (state == STOP);
    assign tmr_restart = ((state == START) && half_done) ||
                         (((state == DATA) || (state == STOP)) && period_done);
    assign tmr_bit_inc = (state == DATA) && period_done;

    rx_bit_timer #(
        .NUM_DATA_BITS (NUM_DATA_BITS),
        .CLKS_PER_BIT  (CLKS_PER_BIT)
    ) u_timer (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (tmr_clear),
        .count_en    (tmr_count),
        .restart     (tmr_restart),
        .bit_inc     (tmr_bit_inc),
        .half_done   (half_done),
        .period_pre  (period_pre),
        .period_done (period_done),
        .bits_done   (bits_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            shift_strobe  <= 1'b0;
            load_buffer   <= 1'b0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            shift_strobe <= 1'b0;
            load_buffer  <= 1'b0;
            if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        state         <= START;
                        busy          <= 1'b1;
                        framing_error <= 1'b0;
                    end
                end
                START: begin
                    if (half_done) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (period_pre) begin
                        shift_strobe <= 1'b1;
                    end
                    if (period_done && bits_done) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (period_done) begin
                        if (rx_s) begin
                            state       <= LOAD;
                            load_buffer <= 1'b1;
                        end else begin
                            state         <= IDLE;
                            framing_error <= 1'b1;
                            busy          <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    data_ready <= 1'b1;
                    if (data_ready && !data_read) begin
                        overrun_error <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_bit_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rx_bit_sequencer : cycle-accurate expectation tables for rx_bit_sequencer
// Rev 1.0
// ============================================================================
module tb_rx_bit_sequencer;

    localparam int NB   = 8;
    localparam int CPB  = 10;
    localparam int MAXC = 8192;

    // Frame timing relative to the cycle the line is driven low
    localparam int SYNC     = 2;
    localparam int BUSY_OFS = SYNC + 1;
    localparam int FIRST    = BUSY_OFS + CPB / 2 + CPB - 1;
    localparam int LOAD_OFS = FIRST + (NB - 1) * CPB + CPB + 1;
    localparam int FRAME    = (NB + 2) * CPB;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic serial_in = 1'b1;
    logic data_read = 1'b0;
    logic shift_strobe, load_buffer, data_ready, framing_error, overrun_error, busy;

    rx_bit_sequencer #(.NUM_DATA_BITS(NB), .CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .shift_strobe  (shift_strobe),
        .load_buffer   (load_buffer),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit         exp_strobe [MAXC];
    bit         exp_load   [MAXC];
    bit         exp_busy   [MAXC];
    bit         exp_fe_set [MAXC];
    bit         exp_fe_clr [MAXC];
    bit         rd         [MAXC];
    logic [7:0] exp_byte   [MAXC];
    bit         m_dr, m_ov, m_fe;

    int checks = 0;
    int passes = 0;
    int rd_permille = 0;
    int force_rd_cyc = -1;
    int strobe_cnt = 0, load_cnt = 0, first_strobe = -1, last_strobe = -1, last_busy = -1;
    logic [7:0] sreg = 8'h00;
    logic [7:0] last_word = 8'h00;
    int n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    endtask

    // Per-cycle comparison against the expectation tables and flag model
    always @(negedge clk) begin
        n = cyc;
        if (n < MAXC) begin
            chk("shift_strobe", {31'd0, shift_strobe}, {31'd0, exp_strobe[n]});
            chk("load_buffer", {31'd0, load_buffer}, {31'd0, exp_load[n]});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy[n]});
            chk("data_ready", {31'd0, data_ready}, {31'd0, m_dr});
            chk("overrun_error", {31'd0, overrun_error}, {31'd0, m_ov});
            chk("framing_error", {31'd0, framing_error}, {31'd0, m_fe});
            if (shift_strobe) begin
                sreg = {serial_in, sreg[7:1]};
                strobe_cnt++;
                if (first_strobe < 0) first_strobe = n;
                last_strobe = n;
            end
            if (busy) last_busy = n;
            if (load_buffer) begin
                load_cnt++;
                last_word = sreg;
                if (exp_load[n]) chk("data_word", {24'd0, sreg}, {24'd0, exp_byte[n]});
            end
            if (n_rst) begin
                if (exp_fe_set[n]) m_fe = 1'b1;
                if (exp_fe_clr[n]) m_fe = 1'b0;
                m_ov = rd[n] ? 1'b0 : (m_ov | (exp_load[n] & m_dr));
                m_dr = exp_load[n] | (m_dr & ~rd[n]);
            end
        end
    end

    task automatic step();
        bit rdv;
        rdv = (force_rd_cyc == cyc) || ($urandom_range(0, 999) < rd_permille);
        data_read = rdv;
        if (cyc < MAXC) rd[cyc] = rdv;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int k);
        serial_in = 1'b1;
        repeat (k) step();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        serial_in = 1'b1;
        for (int i = cyc; i < MAXC; i++) begin
            exp_strobe[i] = 0; exp_load[i] = 0; exp_busy[i] = 0;
            exp_fe_set[i] = 0; exp_fe_clr[i] = 0;
        end
        m_dr = 0; m_ov = 0; m_fe = 0;
        repeat (3) step();
        n_rst = 1'b1;
        repeat (4) step();
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int abort_rel);
        int f;
        int busy_end;
        f = cyc;
        for (int k = 0; k < NB; k++) exp_strobe[f + FIRST + k * CPB] = 1;
        busy_end = stop ? f + LOAD_OFS : f + LOAD_OFS - 1;
        for (int c = f + BUSY_OFS; c <= busy_end; c++) exp_busy[c] = 1;
        exp_fe_clr[f + SYNC] = 1;
        if (stop) begin
            exp_load[f + LOAD_OFS] = 1;
            exp_byte[f + LOAD_OFS] = d;
        end else begin
            exp_fe_set[f + LOAD_OFS - 1] = 1;
        end
        for (int c = 0; c < FRAME; c++) begin
            if (c == abort_rel) begin
                do_reset();
                return;
            end
            if (c < CPB) serial_in = 1'b0;
            else if (c < (NB + 1) * CPB) serial_in = d[c / CPB - 1];
            else serial_in = stop;
            step();
        end
    endtask

    task automatic false_start();
        int f;
        f = cyc;
        exp_fe_clr[f + SYNC] = 1;
        for (int c = f + BUSY_OFS; c <= f + BUSY_OFS + CPB / 2 - 1; c++) exp_busy[c] = 1;
        serial_in = 1'b0;
        repeat (3) step();
        idle(9);
    endtask

    task automatic pulse_read();
        force_rd_cyc = cyc;
        step();
        force_rd_cyc = -1;
    endtask

    int f0, s0, l0, kind, gap;

    initial begin
        repeat (3) step();
        n_rst = 1'b1;
        idle(5);

        // Frame 0x5A: strobe count, placement and captured word
        s0 = strobe_cnt; l0 = load_cnt; first_strobe = -1; f0 = cyc;
        send_frame(8'h5A, 1'b1, -1);
        idle(2);
        chk("t1_strobes", strobe_cnt - s0, 8);
        chk("t1_first_ofs", first_strobe - f0, 17);
        chk("t1_strobe_span", last_strobe - first_strobe, 70);
        chk("t1_loads", load_cnt - l0, 1);
        chk("t1_word", {24'd0, last_word}, 32'h5A);
        chk("t1_ready", {31'd0, data_ready}, 1);
        chk("t1_ferr", {31'd0, framing_error}, 0);

        // Short low glitch
        s0 = strobe_cnt; f0 = cyc;
        false_start();
        chk("t2_strobes", strobe_cnt - s0, 0);
        chk("t2_busy_last", last_busy - f0, 7);
        chk("t2_busy_now", {31'd0, busy}, 0);

        // Bad stop bit
        pulse_read();
        idle(2);
        chk("t3_ready_pre", {31'd0, data_ready}, 0);
        s0 = strobe_cnt; l0 = load_cnt;
        send_frame(8'hFF, 1'b0, -1);
        idle(4);
        chk("t3_strobes", strobe_cnt - s0, 8);
        chk("t3_loads", load_cnt - l0, 0);
        chk("t3_ferr", {31'd0, framing_error}, 1);
        chk("t3_ready", {31'd0, data_ready}, 0);

        // Back-to-back frames without reading
        send_frame(8'h11, 1'b1, -1);
        chk("t4_ferr_cleared", {31'd0, framing_error}, 0);
        chk("t4_word1", {24'd0, last_word}, 32'h11);
        chk("t4_ovr_first", {31'd0, overrun_error}, 0);
        send_frame(8'h22, 1'b1, -1);
        idle(2);
        chk("t4_word2", {24'd0, last_word}, 32'h22);
        chk("t4_ovr", {31'd0, overrun_error}, 1);
        chk("t4_ready", {31'd0, data_ready}, 1);
        pulse_read();
        chk("t4_ready_clr", {31'd0, data_ready}, 0);
        chk("t4_ovr_clr", {31'd0, overrun_error}, 0);

        // Read coinciding with the load cycle
        send_frame(8'h33, 1'b1, -1);
        force_rd_cyc = cyc + LOAD_OFS;
        send_frame(8'h44, 1'b1, -1);
        force_rd_cyc = -1;
        idle(2);
        chk("t6_ovr", {31'd0, overrun_error}, 0);
        chk("t6_ready", {31'd0, data_ready}, 1);
        chk("t6_word", {24'd0, last_word}, 32'h44);

        // Reset after the 4th strobe, then a clean frame
        s0 = strobe_cnt;
        send_frame(8'hC3, 1'b1, 50);
        chk("t5_strobes_aborted", strobe_cnt - s0, 4);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_ready", {31'd0, data_ready}, 0);
        idle(3);
        s0 = strobe_cnt; l0 = load_cnt;
        send_frame(8'hA5, 1'b1, -1);
        idle(2);
        chk("t5_strobes", strobe_cnt - s0, 8);
        chk("t5_loads", load_cnt - l0, 1);
        chk("t5_word", {24'd0, last_word}, 32'hA5);

        // Randomized traffic
        rd_permille = 20;
        for (int it = 0; it < 30; it++) begin
            if (cyc > MAXC - 2 * FRAME) break;
            kind = $urandom_range(0, 19);
            if (kind < 3) begin
                false_start();
            end else if (kind < 6) begin
                send_frame(8'($urandom), 1'b0, -1);
                idle($urandom_range(3, 12));
            end else begin
                send_frame(8'($urandom), 1'b1, -1);
                gap = $urandom_range(0, 1) ? 0 : $urandom_range(3, 12);
                idle(gap);
            end
        end
        rd_permille = 0;
        idle(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
